// File: rtl/pid_cmd_pkg.sv
// rtl/pid_cmd_pkg.sv - shared constants and types for the PID command UART receiver
// Contents: packet header byte, register address map, parser and byte-receiver
// state encodings, packet checksum helper.
package pid_cmd_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [7:0] {
        ADDR_KP = 8'h00,
        ADDR_KI = 8'h01,
        ADDR_KD = 8'h02,
        ADDR_SP = 8'h03
    } addr_e;

    typedef enum logic [2:0] {
        P_WAIT_HDR,
        P_ADDR,
        P_DHI,
        P_DLO,
        P_CHK
    } parser_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic logic [7:0] pkt_chk(input logic [7:0] addr,
                                           input logic [7:0] data_hi,
                                           input logic [7:0] data_lo);
        return addr ^ data_hi ^ data_lo;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style UART byte receiver with input synchroniser
// Ports: clk, reset_n (async active-low), serial_rx (raw line, idles high),
// byte_valid (1-cycle pulse with dout valid), dout (received byte, LSB first on
// the wire), frame_err (1-cycle pulse when the stop bit samples low).
module uart_rx
    import pid_cmd_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  serial_rx,
    output logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [1:0]            sync_q;
    logic                  rx_s;
    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  valid_d, ferr_d;

    // Two-flop synchroniser; resets to the idle (high) level so reset release
    // never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], serial_rx};
    end
    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            byte_valid <= valid_d;
            frame_err  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit check rejects short glitches without an error.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                // Returning to IDLE at mid-stop leaves half a bit of margin for
                // a back-to-back start bit.
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign dout = shreg_q;

endmodule

// File: rtl/pid_cmd_uart_rx.sv
// rtl/pid_cmd_uart_rx.sv - UART command parser and PID gain/setpoint register file
// Ports: clk, reset_n (async active-low), uart_serial_rx (idles high),
// k_p/k_i/k_d (gain registers), setpoint (distance in cm),
// cmd_valid (1-cycle pulse on register write), cmd_err (1-cycle pulse on
// framing, checksum, address or inter-byte timeout error).
module pid_cmd_uart_rx
    import pid_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 1085,
    parameter int GAIN_WIDTH     = 16,
    parameter int SETPOINT_WIDTH = 7,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      uart_serial_rx,
    output logic [GAIN_WIDTH-1:0]     k_p,
    output logic [GAIN_WIDTH-1:0]     k_i,
    output logic [GAIN_WIDTH-1:0]     k_d,
    output logic [SETPOINT_WIDTH-1:0] setpoint,
    output logic                      cmd_valid,
    output logic                      cmd_err
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_M1 = TO_W'(TO_LIMIT - 1);
    localparam logic [SETPOINT_WIDTH-1:0] SP_RESET = SETPOINT_WIDTH'(30);

    // Reset asserts immediately but releases two clocks later, synchronously.
    logic [1:0] rst_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_q <= 2'b00;
        else          rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n_int = rst_q[1];

    logic       byte_valid;
    logic       frame_err;
    logic [7:0] rx_byte;

    uart_rx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk        (clk),
        .reset_n    (rst_n_int),
        .serial_rx  (uart_serial_rx),
        .byte_valid (byte_valid),
        .dout       (rx_byte),
        .frame_err  (frame_err)
    );

    parser_state_e   p_q, p_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      dhi_q, dhi_d;
    logic [7:0]      dlo_q, dlo_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            valid_d, err_d, wr_en;
    logic [15:0]     wr_data;

    assign wr_data = {dhi_q, dlo_q};

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            p_q       <= P_WAIT_HDR;
            addr_q    <= '0;
            dhi_q     <= '0;
            dlo_q     <= '0;
            to_q      <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            k_p       <= '0;
            k_i       <= '0;
            k_d       <= '0;
            setpoint  <= SP_RESET;
        end else begin
            p_q       <= p_d;
            addr_q    <= addr_d;
            dhi_q     <= dhi_d;
            dlo_q     <= dlo_d;
            to_q      <= to_d;
            cmd_valid <= valid_d;
            cmd_err   <= err_d;
            if (wr_en) begin
                case (addr_q)
                    ADDR_KP: k_p      <= GAIN_WIDTH'(wr_data);
                    ADDR_KI: k_i      <= GAIN_WIDTH'(wr_data);
                    ADDR_KD: k_d      <= GAIN_WIDTH'(wr_data);
                    ADDR_SP: setpoint <= SETPOINT_WIDTH'(wr_data);
                    default: ;
                endcase
            end
        end
    end

    // byte_valid and frame_err are mutually exclusive, and a received byte
    // takes priority over the timeout, so cmd_valid and cmd_err cannot coincide.
    always_comb begin
        p_d     = p_q;
        addr_d  = addr_q;
        dhi_d   = dhi_q;
        dlo_d   = dlo_q;
        to_d    = to_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        if (frame_err) begin
            p_d   = P_WAIT_HDR;
            err_d = 1'b1;
            to_d  = '0;
        end else if (byte_valid) begin
            to_d = '0;
            case (p_q)
                P_WAIT_HDR: if (rx_byte == HDR_BYTE) p_d = P_ADDR;
                P_ADDR: begin
                    addr_d = rx_byte;
                    p_d    = P_DHI;
                end
                P_DHI: begin
                    dhi_d = rx_byte;
                    p_d   = P_DLO;
                end
                P_DLO: begin
                    dlo_d = rx_byte;
                    p_d   = P_CHK;
                end
                P_CHK: begin
                    p_d = P_WAIT_HDR;
                    if (rx_byte == pkt_chk(addr_q, dhi_q, dlo_q) && addr_q <= 8'(ADDR_SP)) begin
                        valid_d = 1'b1;
                        wr_en   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: p_d = P_WAIT_HDR;
            endcase
        end else if (p_q != P_WAIT_HDR) begin
            if (to_q == TO_M1) begin
                p_d   = P_WAIT_HDR;
                err_d = 1'b1;
                to_d  = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end else begin
            to_d = '0;
        end
    end

endmodule

// File: tb/tb_pid_cmd_uart_rx.sv
// tb/tb_pid_cmd_uart_rx.sv - directed self-checking bench for pid_cmd_uart_rx
module tb_pid_cmd_uart_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_serial_rx = 1'b1;
    logic [15:0] k_p, k_i, k_d;
    logic [6:0]  setpoint;
    logic        cmd_valid, cmd_err;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both_cnt = 0;
    int v0, e0;

    pid_cmd_uart_rx #(
        .CLKS_PER_BIT   (CPB),
        .GAIN_WIDTH     (16),
        .SETPOINT_WIDTH (7),
        .TIMEOUT_BITS   (20)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .uart_serial_rx (uart_serial_rx),
        .k_p            (k_p),
        .k_i            (k_i),
        .k_d            (k_d),
        .setpoint       (setpoint),
        .cmd_valid      (cmd_valid),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) vcnt <= vcnt + 1;
        if (cmd_err) ecnt <= ecnt + 1;
        if (cmd_valid && cmd_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_serial_rx = 1'b0;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_serial_rx = b[i];
            clks(CPB);
        end
        uart_serial_rx = 1'b1;
        clks(CPB);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(h);
        send_byte(l);
        send_byte(c);
        clks(2 * CPB);
    endtask

    task automatic snap();
        v0 = vcnt;
        e0 = ecnt;
    endtask

    initial begin
        // Reset state
        clks(5);
        check("rst_kp", 32'(k_p), 32'h0);
        check("rst_ki", 32'(k_i), 32'h0);
        check("rst_kd", 32'(k_d), 32'h0);
        check("rst_sp", 32'(setpoint), 32'd30);
        check("rst_valid", 32'(cmd_valid), 32'h0);
        check("rst_err", 32'(cmd_err), 32'h0);
        reset_n = 1'b1;
        clks(2 * CPB);

        // k_p write
        snap();
        send_pkt(8'h00, 8'h01, 8'h2C, 8'h2D);
        check("kp_val", 32'(k_p), 32'h012C);
        check("kp_vpulse", 32'(vcnt - v0), 32'd1);
        check("kp_epulse", 32'(ecnt - e0), 32'd0);
        check("kp_ki_hold", 32'(k_i), 32'h0);
        check("kp_kd_hold", 32'(k_d), 32'h0);
        check("kp_sp_hold", 32'(setpoint), 32'd30);

        // setpoint then k_d
        snap();
        send_pkt(8'h03, 8'h00, 8'h19, 8'h1A);
        check("sp_val", 32'(setpoint), 32'd25);
        send_pkt(8'h02, 8'hFF, 8'hFF, 8'h02);
        check("kd_val", 32'(k_d), 32'hFFFF);
        check("sp_kd_vpulse", 32'(vcnt - v0), 32'd2);
        check("kp_still", 32'(k_p), 32'h012C);

        // Setpoint upper bits ignored: 0x00C8 -> 0x48
        send_pkt(8'h03, 8'h00, 8'hC8, 8'hCB);
        check("sp_trunc", 32'(setpoint), 32'h48);

        // Bad checksum then a good one
        snap();
        send_pkt(8'h01, 8'h00, 8'h10, 8'h00);
        check("badchk_epulse", 32'(ecnt - e0), 32'd1);
        check("badchk_vpulse", 32'(vcnt - v0), 32'd0);
        check("badchk_ki", 32'(k_i), 32'h0);
        send_pkt(8'h01, 8'h00, 8'h10, 8'h11);
        check("goodchk_ki", 32'(k_i), 32'h0010);
        check("goodchk_vpulse", 32'(vcnt - v0), 32'd1);

        // Address above 0x03
        snap();
        send_pkt(8'h04, 8'h00, 8'h01, 8'h05);
        check("badaddr_epulse", 32'(ecnt - e0), 32'd1);
        check("badaddr_vpulse", 32'(vcnt - v0), 32'd0);

        // Non-header bytes discarded silently
        snap();
        send_byte(8'h3C);
        send_byte(8'h00);
        clks(2 * CPB);
        check("junk_pulses", 32'((vcnt - v0) + (ecnt - e0)), 32'd0);

        // Inter-byte timeout
        snap();
        send_byte(8'hA5);
        send_byte(8'h00);
        clks(15 * CPB);
        check("to_early", 32'(ecnt - e0), 32'd0);
        clks(7 * CPB);
        check("to_epulse", 32'(ecnt - e0), 32'd1);
        check("to_kp_hold", 32'(k_p), 32'h012C);
        send_pkt(8'h00, 8'h12, 8'h34, 8'h26);
        check("to_after_kp", 32'(k_p), 32'h1234);
        check("to_after_vpulse", 32'(vcnt - v0), 32'd1);

        // Framing error: stop bit held low
        snap();
        uart_serial_rx = 1'b0;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_serial_rx = 1'b1;
            clks(CPB);
        end
        uart_serial_rx = 1'b0;
        clks(CPB / 2 + 4);
        uart_serial_rx = 1'b1;
        clks(3 * CPB);
        check("frame_epulse", 32'(ecnt - e0), 32'd1);
        check("frame_vpulse", 32'(vcnt - v0), 32'd0);

        // Short glitch on idle line
        snap();
        uart_serial_rx = 1'b0;
        clks(4);
        uart_serial_rx = 1'b1;
        clks(3 * CPB);
        check("glitch_pulses", 32'((vcnt - v0) + (ecnt - e0)), 32'd0);
        send_pkt(8'h02, 8'h00, 8'h07, 8'h05);
        check("glitch_after_kd", 32'(k_d), 32'h0007);

        // Reset in the middle of the DLO byte
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        uart_serial_rx = 1'b0;
        clks(CPB);
        uart_serial_rx = 1'b1;
        clks(3 * CPB);
        reset_n = 1'b0;
        clks(4);
        check("mid_rst_kp", 32'(k_p), 32'h0);
        check("mid_rst_ki", 32'(k_i), 32'h0);
        check("mid_rst_kd", 32'(k_d), 32'h0);
        check("mid_rst_sp", 32'(setpoint), 32'd30);
        check("mid_rst_flags", 32'({cmd_valid, cmd_err}), 32'h0);
        snap();
        reset_n = 1'b1;
        clks(30 * CPB);
        check("post_rst_pulses", 32'((vcnt - v0) + (ecnt - e0)), 32'd0);
        check("post_rst_sp", 32'(setpoint), 32'd30);
        send_pkt(8'h02, 8'h00, 8'h05, 8'h07);
        check("post_rst_kd", 32'(k_d), 32'h0005);

        check("no_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_cmd_uart_rx.md
PID_CMD_UART_RX -- requirements
Module: pid_cmd_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085, clocks per UART bit (115200 baud at 125 MHz).
REQ-002 Parameter GAIN_WIDTH, default 16, width of each gain register.
REQ-003 Parameter SETPOINT_WIDTH, default 7, width of the distance setpoint in cm.
REQ-004 Parameter TIMEOUT_BITS, default 20, maximum idle gap between packet bytes, in bit times.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 uart_serial_rx  input  1  asynchronous serial line; idles high.
REQ-008 k_p  output  GAIN_WIDTH  proportional gain register.
REQ-009 k_i  output  GAIN_WIDTH  integral gain register.
REQ-010 k_d  output  GAIN_WIDTH  derivative gain register.
REQ-011 setpoint  output  SETPOINT_WIDTH  distance setpoint register.
REQ-012 cmd_valid  output  1  one-cycle pulse when a register is updated.
REQ-013 cmd_err  output  1  one-cycle pulse on framing, checksum, address or timeout error.

Function
REQ-014 Synchronise uart_serial_rx through two flops before any use; the synchronised line is rx_s.
REQ-015 Byte receiver states: IDLE, START, DATA, STOP.
- IDLE->START on rx_s low.
- START samples at CLKS_PER_BIT/2; low -> DATA, high -> IDLE (glitch, no error).
- DATA samples 8 bits LSB first, one every CLKS_PER_BIT clocks.
- STOP samples once more: high -> byte_valid pulse for one cycle; low -> framing error and no byte.
REQ-016 Packet format: 0xA5 header, addr, data_hi, data_lo, chk, where chk = addr XOR data_hi XOR data_lo.
REQ-017 Parser states: WAIT_HDR, ADDR, DHI, DLO, CHK; each accepted byte advances one state.
REQ-018 In WAIT_HDR, any byte other than 0xA5 is discarded silently.
REQ-019 Address map: 0x00 k_p, 0x01 k_i, 0x02 k_d, 0x03 setpoint.
REQ-020 For setpoint, write data[SETPOINT_WIDTH-1:0]; upper bits are ignored.
REQ-021 For GAIN_WIDTH<16, gain writes truncate to the LSBs.
REQ-022 At CHK, a good checksum and valid address update the register one cycle after the chk byte_valid, with cmd_valid pulsed in that same cycle.
REQ-023 At CHK, a bad checksum or an address above 0x03 pulses cmd_err and updates nothing.
- Either way the parser returns to WAIT_HDR.
REQ-024 A framing error in any parser state pulses cmd_err and returns the parser to WAIT_HDR.
REQ-025 A timeout counter runs in parser states other than WAIT_HDR and clears on each byte_valid.
- At TIMEOUT_BITS*CLKS_PER_BIT clocks it pulses cmd_err and returns to WAIT_HDR.
REQ-026 cmd_valid and cmd_err are never asserted in the same cycle.
REQ-027 Registers hold their value between valid commands.
- A write of the value already held still pulses cmd_valid.
REQ-028 A new start bit arriving during the cmd_valid cycle is received normally; back-to-back packets with no idle gap are supported.

Reset
REQ-029 On reset_n low, registers reset asynchronously:
- k_p=0, k_i=0, k_d=0, setpoint=30, cmd_valid=0, cmd_err=0.
- Receiver goes to IDLE, parser to WAIT_HDR, all counters to 0.
REQ-030 Reset asserted mid-byte or mid-packet discards the partial data; no pulse is produced after release.
REQ-031 Reset release is synchronised internally, so the first active edge is clean.

Structure
REQ-032 The shared package pid_cmd_pkg holds:
- the header constant 0xA5;
- the address enum (ADDR_KP, ADDR_KI, ADDR_KD, ADDR_SP);
- the parser state enum.
REQ-033 The byte receiver is a separate sub-module uart_rx, parameterised by DATA_WIDTH and CLKS_PER_BIT, with outputs byte_valid, dout and frame_err; the parser and register file stay in the top module.

Verification (CLKS_PER_BIT=16)
REQ-034 Send A5 00 01 2C 2D -> k_p=0x012C and one cmd_valid pulse; other registers unchanged.
REQ-035 Send A5 03 00 19 1A -> setpoint=25; then A5 02 FF FF 02 -> k_d=0xFFFF.
REQ-036 Send A5 01 00 10 00 (bad chk) -> one cmd_err pulse, k_i stays 0; then a valid packet is accepted.
REQ-037 Send A5 00 then idle for 20 bit times -> cmd_err at the timeout; a following full packet succeeds.
REQ-038 Send a byte with the stop bit held low -> cmd_err; a 4-clock low glitch on idle -> no byte, no error.
REQ-039 Drive reset_n low mid-DLO of a packet -> all outputs at reset values, no pulse after release.
